memory_stage: RTL and testbench

//  MEM stage, directly downstream of the EX/MEM register. Runs loads/stores on a req/gnt/rvalid data bus.

---
 rtl/memory_stage.sv | 215 +++++++++++++++++++++
 tb/tb_memory_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MEM stage: load/store sequencing on a req/gnt/rvalid data bus.
// Types shared with the pipeline live in memory_stage_pkg ahead of the module.
package memory_stage_pkg;
  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    UNKNOWN, ADD, SUB, AND_OP, OR_OP, XOR_OP,
    LB, LH, LW, LBU, LHU, SB, SH, SW
  } operation_e;

  typedef operation_e op_e;

  typedef struct packed {
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
    logic            valid;
  } rd_port_t;
endpackage

module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pcM_i,
  input  logic [XLEN-1:0] instrM_i,
  input  op_e             operationM_i,
  input  rd_port_t        rdM_port_i,
  input  logic            memM_wrt_ena_i,
  input  logic [XLEN-1:0] memM_addr_i,
  input  logic [XLEN-1:0] memM_wrt_data_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic [XLEN-1:0] pcM_o,
  output logic [XLEN-1:0] instrM_o,
  output op_e             operationM_o,
  output rd_port_t        rdM_port_o,
  output logic            stallM_o,
  output logic            misalign_o,
  output logic            bus_err_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            req_q, we_q;
  logic [3:0]      be_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  op_e             cap_op_q;
  logic [XLEN-1:0] cap_pc_q, cap_instr_q;
  logic [4:0]      cap_rd_q;
  logic [1:0]      off_q;
  logic [XLEN-1:0] pc_q, instr_q;
  op_e             op_q;
  rd_port_t        rd_q;
  logic            misalign_q, bus_err_q;

  logic            is_load, is_store, access, misaligned, cap_is_load, timeout;
  logic [1:0]      off;
  logic [3:0]      be_d;
  logic [XLEN-1:0] wdata_d, ld_data;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  always_comb begin
    off      = memM_addr_i[1:0];
    is_load  = operationM_i inside {LB, LH, LW, LBU, LHU};
    is_store = operationM_i inside {SB, SH, SW};
    access   = !flush_i && ((is_load && rdM_port_i.valid) || (is_store && memM_wrt_ena_i));

    misaligned = 1'b0;
    be_d       = 4'b1111;
    wdata_d    = memM_wrt_data_i;
    case (operationM_i)
      LB, LBU, SB: begin
        be_d    = 4'b0001 << off;
        wdata_d = {4{memM_wrt_data_i[7:0]}};
      end
      LH, LHU, SH: begin
        misaligned = off[0];
        be_d       = 4'b0011 << off;
        wdata_d    = {2{memM_wrt_data_i[15:0]}};
      end
      LW, SW:  misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    ld_byte     = dmem_rdata_i[{off_q, 3'b000} +: 8];
    ld_half     = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    cap_is_load = cap_op_q inside {LB, LH, LW, LBU, LHU};
    case (cap_op_q)
      LB:      ld_data = {{24{ld_byte[7]}}, ld_byte};
      LBU:     ld_data = {24'h0, ld_byte};
      LH:      ld_data = {{16{ld_half[15]}}, ld_half};
      LHU:     ld_data = {16'h0, ld_half};
      default: ld_data = dmem_rdata_i;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q + CW'(1);
    timeout  = (cnt_d == CW'(TIMEOUT_CYCLES));
    stallM_o = ((state_q == IDLE) && access && !misaligned) || (state_q == REQ) ||
               ((state_q == RESP) && !dmem_rvalid_i);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cap_op_q    <= UNKNOWN;
      cap_pc_q    <= '0;
      cap_instr_q <= '0;
      cap_rd_q    <= '0;
      off_q       <= '0;
      pc_q        <= '0;
      instr_q     <= '0;
      op_q        <= UNKNOWN;
      rd_q        <= '0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      pc_q       <= pcM_i;
      instr_q    <= instrM_i;
      op_q       <= operationM_i;
      rd_q       <= '{addr: rdM_port_i.addr, data: rdM_port_i.data, valid: 1'b0};
      case (state_q)
        IDLE: begin
          if (access && misaligned) begin
            misalign_q <= 1'b1;
          end else if (access) begin
            state_q     <= REQ;
            cnt_q       <= '0;
            cap_op_q    <= operationM_i;
            cap_pc_q    <= pcM_i;
            cap_instr_q <= instrM_i;
            cap_rd_q    <= rdM_port_i.addr;
            off_q       <= off;
            req_q       <= 1'b1;
            we_q        <= is_store;
            be_q        <= be_d;
            addr_q      <= {memM_addr_i[XLEN-1:2], 2'b00};
            wdata_q     <= wdata_d;
          end else begin
            rd_q.valid <= rdM_port_i.valid && !flush_i;
          end
        end
        REQ, RESP: begin
          cnt_q <= cnt_d;
          // Completion beats a timeout that lands on the same cycle.
          if ((state_q == RESP) && dmem_rvalid_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= cap_pc_q;
            instr_q <= cap_instr_q;
            op_q    <= cap_op_q;
            rd_q    <= '{addr: cap_rd_q, data: cap_is_load ? ld_data : '0, valid: cap_is_load};
          end else if (timeout) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            bus_err_q <= 1'b1;
          end else if ((state_q == REQ) && dmem_gnt_i) begin
            state_q <= RESP;
            req_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assert property (@(posedge clk_i) disable iff (!rstn_i)
    (state_q != IDLE) |-> !(rdM_port_i.valid || memM_wrt_ena_i));

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_be_o    = be_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign pcM_o        = pc_q;
  assign instrM_o     = instr_q;
  assign operationM_o = op_q;
  assign rdM_port_o   = rd_q;
  assign misalign_o   = misalign_q;
  assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - scoreboard bench for memory_stage.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic            clk_i = 1'b0;
  logic            rstn_i, flush_i;
  logic [31:0]     pcM_i, instrM_i;
  op_e             operationM_i;
  rd_port_t        rdM_port_i;
  logic            memM_wrt_ena_i;
  logic [31:0]     memM_addr_i, memM_wrt_data_i;
  logic            dmem_req_o, dmem_we_o;
  logic [3:0]      dmem_be_o;
  logic [31:0]     dmem_addr_o, dmem_wdata_o;
  logic            dmem_gnt_i, dmem_rvalid_i;
  logic [31:0]     dmem_rdata_i;
  logic [31:0]     pcM_o, instrM_o;
  op_e             operationM_o;
  rd_port_t        rdM_port_o;
  logic            stallM_o, misalign_o, bus_err_o;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  memory_stage #(.TIMEOUT_CYCLES(64)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
    .pcM_i(pcM_i), .instrM_i(instrM_i), .operationM_i(operationM_i),
    .rdM_port_i(rdM_port_i), .memM_wrt_ena_i(memM_wrt_ena_i),
    .memM_addr_i(memM_addr_i), .memM_wrt_data_i(memM_wrt_data_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .pcM_o(pcM_o), .instrM_o(instrM_o), .operationM_o(operationM_o),
    .rdM_port_o(rdM_port_o), .stallM_o(stallM_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
  endtask

  always @(negedge clk_i) begin
    if (rstn_i && rdM_port_o.valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wb", {27'h0, rdM_port_o.addr}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wb_rd", {27'h0, rdM_port_o.addr}, {27'h0, e.rd});
        check("wb_data", rdM_port_o.data, e.data);
      end
    end
  end

  task automatic bubble();
    flush_i         = 1'b0;
    pcM_i           = 32'h444;
    instrM_i        = 32'h13;
    operationM_i    = UNKNOWN;
    rdM_port_i      = '0;
    memM_wrt_ena_i  = 1'b0;
    memM_addr_i     = 32'h0;
    memM_wrt_data_i = 32'h0;
  endtask

  task automatic drive_mem(input op_e op, input logic [31:0] addr, input logic [31:0] sdata);
    logic ld;
    ld              = op inside {LB, LH, LW, LBU, LHU};
    flush_i         = 1'b0;
    pcM_i           = 32'h1000;
    instrM_i        = 32'h0000_2003;
    operationM_i    = op;
    rdM_port_i      = '{addr: 5'd10, data: 32'h0, valid: ld};
    memM_wrt_ena_i  = !ld;
    memM_addr_i     = addr;
    memM_wrt_data_i = sdata;
  endtask

  // Called at a negedge; returns at the negedge after the completion edge.
  task automatic access(input string tag, input op_e op, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rdata,
                        input logic [31:0] exp_data, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata);
    logic ld;
    ld = op inside {LB, LH, LW, LBU, LHU};
    drive_mem(op, addr, sdata);
    if (ld) exp_q.push_back('{rd: 5'd10, data: exp_data});
    #1 check({tag, "_stall_issue"}, {31'h0, stallM_o}, 32'h1);
    @(negedge clk_i);
    bubble();
    #1;
    check({tag, "_req"}, {31'h0, dmem_req_o}, 32'h1);
    check({tag, "_addr"}, dmem_addr_o, addr & 32'hFFFF_FFFC);
    check({tag, "_we"}, {31'h0, dmem_we_o}, {31'h0, !ld});
    check({tag, "_stall_req"}, {31'h0, stallM_o}, 32'h1);
    if (!ld) begin
      check({tag, "_be"}, {28'h0, dmem_be_o}, {28'h0, exp_be});
      check({tag, "_wdata"}, dmem_wdata_o, exp_wdata);
    end
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = rdata;
    #1;
    check({tag, "_req_drop"}, {31'h0, dmem_req_o}, 32'h0);
    check({tag, "_stall_rvalid"}, {31'h0, stallM_o}, 32'h0);
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    check({tag, "_op_out"}, 32'(operationM_o), 32'(op));
    check({tag, "_pc_out"}, pcM_o, 32'h1000);
  endtask

  task automatic misalign_case(input string tag, input op_e op, input logic [31:0] addr);
    drive_mem(op, addr, 32'hA5A5_A5A5);
    #1 check({tag, "_stall"}, {31'h0, stallM_o}, 32'h0);
    @(negedge clk_i);
    bubble();
    #1;
    check({tag, "_pulse"}, {31'h0, misalign_o}, 32'h1);
    check({tag, "_noreq"}, {31'h0, dmem_req_o}, 32'h0);
    check({tag, "_stall_after"}, {31'h0, stallM_o}, 32'h0);
    @(negedge clk_i);
    check({tag, "_pulse_end"}, {31'h0, misalign_o}, 32'h0);
    check({tag, "_noreq_end"}, {31'h0, dmem_req_o}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rstn_i        = 1'b0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'h0;
    bubble();
    repeat (2) @(negedge clk_i);
    check("rst_req", {31'h0, dmem_req_o}, 32'h0);
    check("rst_op", 32'(operationM_o), 32'(UNKNOWN));
    check("rst_rd", {27'h0, rdM_port_o.addr}, 32'h0);
    check("rst_pc", pcM_o, 32'h0);
    check("rst_flags", {29'h0, misalign_o, bus_err_o, rdM_port_o.valid}, 32'h0);
    rstn_i = 1'b1;
    @(negedge clk_i);

    access("lw", LW, 32'h100, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'h0, 32'h0);
    access("lb", LB, 32'h103, 32'h0, 32'h80FF_FFFF, 32'hFFFF_FF80, 4'h0, 32'h0);
    access("lbu", LBU, 32'h103, 32'h0, 32'h80FF_FFFF, 32'h0000_0080, 4'h0, 32'h0);
    access("lhu", LHU, 32'h102, 32'h0, 32'h80FF_FFFF, 32'h0000_80FF, 4'h0, 32'h0);
    access("lh", LH, 32'h102, 32'h0, 32'h80FF_1234, 32'hFFFF_80FF, 4'h0, 32'h0);
    access("sb", SB, 32'h201, 32'h1234_5678, 32'h0, 32'h0, 4'b0010, 32'h7878_7878);
    access("sh", SH, 32'h202, 32'h1234_5678, 32'h0, 32'h0, 4'b1100, 32'h5678_5678);
    access("sw", SW, 32'h204, 32'hCAFE_F00D, 32'h0, 32'h0, 4'b1111, 32'hCAFE_F00D);

    misalign_case("mis_sh", SH, 32'h201);
    misalign_case("mis_lw", LW, 32'h102);

    // ALU pass-through, second op squashed by flush.
    flush_i        = 1'b0;
    operationM_i   = ADD;
    pcM_i          = 32'h2000;
    rdM_port_i     = '{addr: 5'd5, data: 32'd7, valid: 1'b1};
    memM_wrt_ena_i = 1'b0;
    exp_q.push_back('{rd: 5'd5, data: 32'd7});
    #1 check("add_stall", {31'h0, stallM_o}, 32'h0);
    @(negedge clk_i);
    check("add_op", 32'(operationM_o), 32'(ADD));
    flush_i = 1'b1;
    pcM_i   = 32'h2004;
    @(negedge clk_i);
    check("flush_valid", {31'h0, rdM_port_o.valid}, 32'h0);
    check("flush_pc", pcM_o, 32'h2004);
    bubble();
    @(negedge clk_i);

    // Timeout: grant never arrives.
    drive_mem(LW, 32'h300, 32'h0);
    @(negedge clk_i);
    bubble();
    n = 1;
    while (!bus_err_o && n < 200) begin
      if (n == 64) check("to_req_held", {31'h0, dmem_req_o}, 32'h1);
      @(negedge clk_i);
      n++;
    end
    check("to_cycles", n, 65);
    check("to_req_drop", {31'h0, dmem_req_o}, 32'h0);
    check("to_stall_rel", {31'h0, stallM_o}, 32'h0);
    check("to_rd_valid", {31'h0, rdM_port_o.valid}, 32'h0);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h5555_5555;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    check("to_err_pulse_end", {31'h0, bus_err_o}, 32'h0);
    @(negedge clk_i);
    access("lw_after_to", LW, 32'h104, 32'h0, 32'h0BAD_F00D, 32'h0BAD_F00D, 4'h0, 32'h0);

    // Reset while waiting for the response.
    drive_mem(LW, 32'h400, 32'h0);
    @(negedge clk_i);
    bubble();
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    check("rr_pc_pass", pcM_o, 32'h444);
    check("rr_stall_resp", {31'h0, stallM_o}, 32'h1);
    rstn_i = 1'b0;
    #1;
    check("rr_req", {31'h0, dmem_req_o}, 32'h0);
    check("rr_pc", pcM_o, 32'h0);
    check("rr_op", 32'(operationM_o), 32'(UNKNOWN));
    check("rr_stall", {31'h0, stallM_o}, 32'h0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
